// File: rtl/gain_ramp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gain_ramp_ctrl_if
// Brief    : Target-gain configuration handshake between sound registers
//            and the gain ramp controller.
// Revision : 1.0 - initial release
// ============================================================================
interface gain_ramp_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [3:0] cfg_gain;

  modport master (
    output cfg_valid,
    output cfg_gain,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_gain,
    output cfg_ready
  );
endinterface
`default_nettype wire

// File: rtl/gain_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gain_ramp_ctrl
// Brief    : Strobe-paced gain ramp toward a programmed target, with mute
//            and clip-driven AGC, driving the amplifier 4-bit gain input.
// Revision : 1.0 - initial release
// ============================================================================
module gain_ramp_ctrl #(
  parameter int RAMP_DIV   = 256,
  parameter int WIN        = 4096,
  parameter int CLIP_LIMIT = 8,
  parameter int INIT_GAIN  = 1
) (
  input  wire logic        clk_sys,
  input  wire logic        reset_n,
  input  wire logic        sample_stb,
  gain_ramp_ctrl_if.slave  cfg,
  input  wire logic        mute_in,
  input  wire logic        agc_en,
  input  wire logic        clip_in,
  output logic [3:0]       gain,
  output logic             busy,
  output logic             agc_event
);

  localparam int DIV_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WIN_W  = $clog2(WIN);
  localparam int CLIP_W = $clog2(CLIP_LIMIT + 1);

  localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(RAMP_DIV - 1);
  localparam logic [WIN_W-1:0]  c_win_last = WIN_W'(WIN - 1);
  localparam logic [CLIP_W-1:0] c_clip_lim = CLIP_W'(CLIP_LIMIT);
  localparam logic [3:0]        c_init     = 4'(INIT_GAIN);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_gain;
  logic [3:0]          r_target;
  logic [DIV_W-1:0]    r_div;
  logic [WIN_W-1:0]    r_win;
  logic [CLIP_W-1:0]   r_clip;
  logic                r_agc_event;

  logic [3:0]          w_eff;
  logic [3:0]          w_target_nxt;
  logic [3:0]          w_eff_nxt;
  logic                w_accept;
  logic                w_agc_act;
  logic [CLIP_W-1:0]   w_clip_inc;
  logic                w_trig;
  logic                w_agc_dec;
  logic                w_step;
  logic                w_ready;
  logic                w_busy;

  assign w_eff     = mute_in ? 4'd0 : r_target;
  assign w_accept  = cfg.cfg_valid && (r_state == ST_IDLE);
  assign w_agc_act = agc_en && !mute_in;

  // The trigger fires on the strobe that brings the clip count to the limit,
  // so the counter itself never rests at CLIP_LIMIT.
  assign w_clip_inc = (r_clip != c_clip_lim) ? (r_clip + 1'b1) : r_clip;
  assign w_trig     = w_agc_act && sample_stb && clip_in && (w_clip_inc == c_clip_lim);
  assign w_agc_dec  = w_trig && !w_accept && (r_target > 4'd1);

  assign w_target_nxt = w_accept  ? cfg.cfg_gain :
                        w_agc_dec ? (r_target - 4'd1) : r_target;
  assign w_eff_nxt    = mute_in ? 4'd0 : w_target_nxt;

  assign w_step = (r_state == ST_RAMP) && sample_stb &&
                  (r_div == c_div_last) && (r_gain != w_eff);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving IDLE looks at the target being written on this edge so that a
  // config accept or AGC reduction drops cfg_ready on the very next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (r_gain != w_eff_nxt) begin
          w_state_nxt = ST_RAMP;
        end
      end
      ST_RAMP: begin
        w_busy = 1'b1;
        if (r_gain == w_eff) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Held at zero outside RAMP, which also gives the clear on RAMP entry.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= '0;
    end else if (r_state != ST_RAMP) begin
      r_div <= '0;
    end else if (sample_stb) begin
      r_div <= (r_div == c_div_last) ? '0 : (r_div + 1'b1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_gain <= 4'd0;
    end else if (w_step) begin
      r_gain <= (r_gain < w_eff) ? (r_gain + 4'd1) : (r_gain - 4'd1);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_target    <= c_init;
      r_agc_event <= 1'b0;
    end else begin
      r_target    <= w_target_nxt;
      r_agc_event <= w_agc_dec;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_win  <= '0;
      r_clip <= '0;
    end else if (!w_agc_act || w_trig) begin
      r_win  <= '0;
      r_clip <= '0;
    end else if (sample_stb) begin
      if (r_win == c_win_last) begin
        r_win  <= '0;
        r_clip <= '0;
      end else begin
        r_win  <= r_win + 1'b1;
        r_clip <= clip_in ? w_clip_inc : r_clip;
      end
    end
  end

  assign gain          = r_gain;
  assign busy          = w_busy;
  assign agc_event     = r_agc_event;
  assign cfg.cfg_ready = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_gain_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gain_ramp_ctrl
// Brief    : Directed self-checking bench for gain_ramp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gain_ramp_ctrl;

  localparam int RAMP_DIV   = 4;
  localparam int WIN        = 16;
  localparam int CLIP_LIMIT = 3;
  localparam int INIT_GAIN  = 1;

  logic       clk_sys    = 1'b0;
  logic       reset_n    = 1'b0;
  logic       sample_stb = 1'b0;
  logic       mute_in    = 1'b0;
  logic       agc_en     = 1'b0;
  logic       clip_in    = 1'b0;
  logic [3:0] gain;
  logic       busy;
  logic       agc_event;

  int checks    = 0;
  int failures  = 0;
  int evt_cnt   = 0;

  gain_ramp_ctrl_if cfg_if ();

  gain_ramp_ctrl #(
    .RAMP_DIV   (RAMP_DIV),
    .WIN        (WIN),
    .CLIP_LIMIT (CLIP_LIMIT),
    .INIT_GAIN  (INIT_GAIN)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .sample_stb (sample_stb),
    .cfg        (cfg_if),
    .mute_in    (mute_in),
    .agc_en     (agc_en),
    .clip_in    (clip_in),
    .gain       (gain),
    .busy       (busy),
    .agc_event  (agc_event)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (agc_event === 1'b1) evt_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic stb_pulse(input logic clip);
    sample_stb = 1'b1;
    clip_in    = clip;
    tick();
    sample_stb = 1'b0;
    clip_in    = 1'b0;
  endtask

  // Each gain step takes RAMP_DIV strobes; gain must move only on the last one.
  task automatic ramp_expect(input int start, input int dir, input int steps);
    int exp_g;
    for (int s = 1; s <= steps; s++) begin
      for (int k = 1; k <= RAMP_DIV; k++) begin
        stb_pulse(1'b0);
        exp_g = (k == RAMP_DIV) ? (start + dir * s) : (start + dir * (s - 1));
        check("ramp_gain", 32'(gain), 32'(exp_g));
        tick();
      end
    end
  endtask

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_gain  = 4'd0;

    // 1: reset state and power-up ramp to INIT_GAIN
    repeat (3) tick();
    check("rst_gain",  32'(gain), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check("rst_agc",   32'(agc_event), 32'd0);
    check("rst_target", 32'(dut.r_target), 32'(INIT_GAIN));
    reset_n = 1'b1;
    check("rel_gain", 32'(gain), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    tick();
    check("pwrup_busy",  32'(busy), 32'd1);
    check("pwrup_ready", 32'(cfg_if.cfg_ready), 32'd0);
    ramp_expect(0, 1, 1);
    check("pwrup_done_busy",  32'(busy), 32'd0);
    check("pwrup_done_ready", 32'(cfg_if.cfg_ready), 32'd1);

    // 2: ramp up to 5, down to 1, and a no-op config equal to gain
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd5;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("up_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("up_busy",  32'(busy), 32'd1);
    ramp_expect(1, 1, 4);
    check("up_done_busy", 32'(busy), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("dn_ready", 32'(cfg_if.cfg_ready), 32'd0);
    ramp_expect(5, -1, 4);
    check("dn_done_busy", 32'(busy), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd1;
    tick();
    cfg_if.cfg_valid = 1'b0;
    check("same_ready", 32'(cfg_if.cfg_ready), 32'd1);
    check("same_busy",  32'(busy), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd5;
    tick();
    cfg_if.cfg_valid = 1'b0;
    ramp_expect(1, 1, 4);

    // 3: mute ramps to 0 ignoring config, unmute returns to the kept target
    mute_in = 1'b1;
    tick();
    check("mute_busy",  32'(busy), 32'd1);
    check("mute_ready", 32'(cfg_if.cfg_ready), 32'd0);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd12;
    ramp_expect(5, -1, 1);
    check("mute_cfg_ignored", 32'(dut.r_target), 32'd5);
    cfg_if.cfg_valid = 1'b0;
    ramp_expect(4, -1, 4);
    check("mute_done_busy", 32'(busy), 32'd0);
    check("mute_target",    32'(dut.r_target), 32'd5);
    mute_in = 1'b0;
    tick();
    check("unmute_busy", 32'(busy), 32'd1);
    ramp_expect(0, 1, 5);
    check("unmute_target", 32'(dut.r_target), 32'd5);
    check("unmute_busy_done", 32'(busy), 32'd0);

    // 4a: three clips inside one window lower the target by one
    agc_en = 1'b1;
    tick();
    stb_pulse(1'b1);
    check("agc_clip1", 32'(dut.r_clip), 32'd1);
    tick();
    stb_pulse(1'b1);
    tick();
    stb_pulse(1'b1);
    check("agc_event_hi", 32'(agc_event), 32'd1);
    check("agc_target",   32'(dut.r_target), 32'd4);
    check("agc_clip_clr", 32'(dut.r_clip), 32'd0);
    check("agc_busy",     32'(busy), 32'd1);
    tick();
    check("agc_event_lo", 32'(agc_event), 32'd0);
    ramp_expect(5, -1, 1);
    check("agc_done_busy", 32'(busy), 32'd0);
    check("agc_evt_cnt1",  32'(evt_cnt), 32'd1);

    // 4b: two clips, window wrap, two clips -> no reduction
    agc_en = 1'b0;
    tick();
    agc_en = 1'b1;
    stb_pulse(1'b1);
    tick();
    stb_pulse(1'b1);
    tick();
    repeat (13) begin
      stb_pulse(1'b0);
      tick();
    end
    check("win_last", 32'(dut.r_win),  32'(WIN - 1));
    check("win_clip", 32'(dut.r_clip), 32'd2);
    stb_pulse(1'b0);
    check("wrap_win",  32'(dut.r_win),  32'd0);
    check("wrap_clip", 32'(dut.r_clip), 32'd0);
    tick();
    stb_pulse(1'b1);
    tick();
    stb_pulse(1'b1);
    tick();
    check("post_wrap_clip", 32'(dut.r_clip), 32'd2);
    check("post_wrap_evt",  32'(evt_cnt), 32'd1);
    check("post_wrap_tgt",  32'(dut.r_target), 32'd4);

    // 5: config accept on the same edge as the AGC trigger wins
    agc_en = 1'b0;
    tick();
    agc_en = 1'b1;
    stb_pulse(1'b1);
    tick();
    stb_pulse(1'b1);
    tick();
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd9;
    stb_pulse(1'b1);
    cfg_if.cfg_valid = 1'b0;
    check("coll_target", 32'(dut.r_target), 32'd9);
    check("coll_clip",   32'(dut.r_clip), 32'd0);
    check("coll_agc",    32'(agc_event), 32'd0);
    check("coll_busy",   32'(busy), 32'd1);
    tick();
    check("coll_evt_cnt", 32'(evt_cnt), 32'd1);
    ramp_expect(4, 1, 5);
    check("coll_done_busy", 32'(busy), 32'd0);
    agc_en = 1'b0;

    // 6: asynchronous reset mid-ramp
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_gain  = 4'd0;
    tick();
    cfg_if.cfg_valid = 1'b0;
    ramp_expect(9, -1, 6);
    check("mid_busy", 32'(busy), 32'd1);
    stb_pulse(1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_gain",   32'(gain), 32'd0);
    check("arst_busy",   32'(busy), 32'd0);
    check("arst_agc",    32'(agc_event), 32'd0);
    check("arst_ready",  32'(cfg_if.cfg_ready), 32'd1);
    check("arst_target", 32'(dut.r_target), 32'(INIT_GAIN));
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rerun_busy", 32'(busy), 32'd1);
    ramp_expect(0, 1, 1);
    check("rerun_done_busy", 32'(busy), 32'd0);
    check("rerun_gain",      32'(gain), 32'(INIT_GAIN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
